pattern_scan_ctrl: RTL and testbench

Word-level scan controller for the serial "10110" Moore pattern detector. It accepts a WIDTH-bit word over a valid/ready handshake and feeds the bits MSB-first, one per cycle, into the detector. It counts the overlapping matches, records where the first match completed, and reports the result with a one-cycle done pulse. It sits between a word-oriented producer and the bit-serial detector, which it owns and sequences.

---
 rtl/scan_pkg.sv | 23 ++
 rtl/pattern_fsm_10110.sv | 47 ++++
 rtl/pattern_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the word-level "10110" scan controller and its detector.
// Pure declarations: no latency or flow-control behaviour of its own.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  typedef enum logic [2:0] {
    A = 3'd0,
    B = 3'd1,
    C = 3'd2,
    D = 3'd3,
    E = 3'd4,
    F = 3'd5
  } det_state_t;

  localparam logic [4:0] PATTERN = 5'b10110;

endpackage

// File: rtl/pattern_fsm_10110.sv
// Bit-serial Moore detector for PATTERN with overlap; w is high the cycle after the completing bit.
// One bit per enabled cycle, no backpressure; clr (synchronous) wins over en.
module pattern_fsm_10110
  import scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic j,
  output logic w
);

  det_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= A;
    end else begin
      state_q <= state_d;
    end
  end

  // Each state is the length of the matched prefix; a mismatch falls back to the
  // longest suffix that is still a prefix, and F continues as if it had seen "10".
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = A;
    end else if (en) begin
      case (state_q)
        A:       state_d = (j == PATTERN[4]) ? B : A;
        B:       state_d = (j == PATTERN[3]) ? C : B;
        C:       state_d = (j == PATTERN[2]) ? D : A;
        D:       state_d = (j == PATTERN[1]) ? E : C;
        E:       state_d = (j == PATTERN[0]) ? F : B;
        F:       state_d = (j == PATTERN[2]) ? D : A;
        default: state_d = A;
      endcase
    end
  end

  always_comb begin
    w = (state_q == F);
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Scans a WIDTH-bit word MSB-first through pattern_fsm_10110; result pulses WIDTH+2 cycles after accept.
// in_ready only in IDLE, nothing buffered; SCAN_CARRY_EN keeps detector state across words.
module pattern_scan_ctrl
  import scan_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [CW-1:0]    match_cnt,
  output logic [CW-1:0]    first_idx,
  output logic             hit
);

`ifdef SCAN_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  scan_state_t      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    first_q, first_d;
  logic             hit_q, hit_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             det_clr, det_en, det_j, det_w;
  logic             credit;
  logic [CW-1:0]    credit_idx;

  pattern_fsm_10110 u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (det_en),
    .j   (det_j),
    .w   (det_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_idx_q   <= '0;
      cnt_q       <= '0;
      first_q     <= '0;
      hit_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_idx_q   <= bit_idx_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      hit_q       <= hit_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (bit_idx_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    accept     = in_valid && in_ready;
    det_en     = (state_q == SHIFT);
    det_clr    = accept && !CARRY_EN;
    det_j      = sr_q[WIDTH-1];
    sr_d       = sr_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    hit_d      = hit_q;
    credit     = 1'b0;
    credit_idx = LAST_IDX;

    // w lags the detector input by one cycle, so the first SHIFT cycle shows the
    // previous word's last bit and the credited index is always bit_idx-1.
    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d      = in_data;
          bit_idx_d = '0;
          cnt_d     = '0;
          first_d   = '0;
          hit_d     = 1'b0;
        end
      end
      SHIFT: begin
        sr_d       = {sr_q[WIDTH-2:0], 1'b0};
        bit_idx_d  = bit_idx_q + ONE;
        credit     = det_w && (bit_idx_q != '0);
        credit_idx = bit_idx_q - ONE;
      end
      DRAIN: credit = det_w;
      default: ;
    endcase

    if (credit) begin
      cnt_d = cnt_q + ONE;
      if (!hit_q) begin
        hit_d   = 1'b1;
        first_d = credit_idx;
      end
    end

    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign match_cnt = cnt_q;
  assign first_idx = first_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: directed words, mid-scan resets, then random words vs a sliding-window model.
module tb_pattern_scan_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

`ifdef SCAN_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, busy, out_valid, hit;
  logic [CW-1:0] match_cnt, first_idx;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .match_cnt (match_cnt),
    .first_idx (first_idx),
    .hit       (hit)
  );

  typedef struct {
    int cnt;
    int idx;
    bit hit;
    int cyc;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_acc = -1;
  bit         prev_ov = 1'b0;
  logic [4:0] win = '0;
  int         nbits = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: slide a 5-bit window over the bit stream; every position where the
  // window equals the pattern is a match ending at that bit.
  task automatic model(input logic [W-1:0] d, output int c, output int fi, output bit h);
    c = 0;
    fi = 0;
    h = 1'b0;
    if (!CARRY) nbits = 0;
    for (int i = 0; i < W; i++) begin
      win = {win[3:0], d[W-1-i]};
      nbits++;
      if (nbits >= 5 && win == 5'b10110) begin
        c++;
        if (!h) begin
          h = 1'b1;
          fi = i;
        end
      end
    end
  endtask

  // Offers d (after idle cycles with in_valid low) until accepted; leaves in_valid high.
  task automatic send(input logic [W-1:0] d, input int idle, input bit dir,
                      input int dc, input int di, input bit dh);
    exp_t e;
    int   mc, mi;
    bit   mh;
    bit   ok;
    ok = 1'b0;
    for (int k = 0; k < idle; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      ok       = in_ready;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b after 40 cycles, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    if (idle == 0 && last_acc >= 0) check("accept_spacing", cyc - last_acc, W + 3);
    last_acc = cyc;
    model(d, mc, mi, mh);
    e.cyc = cyc;
    if (dir) begin
      e.cnt = dc;
      e.idx = di;
      e.hit = dh;
    end else begin
      e.cnt = mc;
      e.idx = mi;
      e.hit = mh;
    end
    sbq.push_back(e);
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),  1);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_match_cnt"}, int'(match_cnt), 0);
    check({tag, "_first_idx"}, int'(first_idx), 0);
    check({tag, "_hit"},       int'(hit),       0);
  endtask

  task automatic abort_after(input logic [W-1:0] d, input int cycles, input string tag);
    send(d, 2, 1'b0, 0, 0, 1'b0);
    repeat (cycles - 1) @(posedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    sbq.delete();
    nbits    = 0;
    last_acc = -1;
    rst      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) check("ready_low_while_busy", int'(in_ready), 0);
      if (out_valid) begin
        check("out_valid_single_cycle", int'(prev_ov), 0);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid: out_valid=1 with no word pending (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("match_cnt", int'(match_cnt), mon_e.cnt);
          check("first_idx", int'(first_idx), mon_e.idx);
          check("hit",       int'(hit),       int'(mon_e.hit));
          check("latency",   cyc - mon_e.cyc, W + 2);
        end
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  initial begin
    logic [W-1:0] x, d;
    int           s;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    send(8'b1011_0000, 1, 1'b1, 1, 4, 1'b1);
    send(8'b1011_0110, 0, 1'b1, 2, 4, 1'b1);
    send(8'hFF,        0, 1'b1, 0, 0, 1'b0);
    send(8'b0001_0110, 0, 1'b1, 1, 7, 1'b1);
    send(8'b0000_0101, 0, 1'b1, 0, 0, 1'b0);
    send(8'b1000_0000, 0, 1'b1, CARRY ? 1 : 0, CARRY ? 1 : 0, CARRY);

    abort_after(8'b1011_0110, 4, "abort_c4");
    send(8'b1011_0000, 2, 1'b1, 1, 4, 1'b1);
    abort_after(8'b1011_0110, 9, "abort_c9");
    send(8'b1011_0110, 2, 1'b1, 2, 4, 1'b1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        x = {5'b10110, 3'($urandom)};
        s = $urandom_range(0, W - 1);
        d = (x << s) | (x >> (W - s));
      end else begin
        d = W'($urandom);
      end
      send(d, $urandom_range(0, 2), 1'b0, 0, 0, 1'b0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 60 && sbq.size() != 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
